// File: rtl/board_display_encoder_pkg.sv
// Shared types, sizes and tile encoding for the 2048 board display encoder.
package board_disp_pkg;

  localparam int TILES      = 16;
  localparam int TILE_W     = 12;
  localparam int SCORE_W    = 17;
  localparam int BCD_DIGITS = 6;
  localparam int CODE_W     = 4;

  localparam logic [CODE_W-1:0] TILE_CODE_EMPTY = 4'd0;
  localparam logic [CODE_W-1:0] TILE_CODE_BAD   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ENCODE,
    ST_BCD,
    ST_PRESENT
  } disp_state_t;

  // Legal tiles are 0 and 2..2048 (powers of two); anything else maps to BAD.
  function automatic logic [CODE_W-1:0] tile_to_code(input logic [TILE_W-1:0] value);
    logic [CODE_W-1:0] code;
    code = TILE_CODE_BAD;
    if (value == '0) code = TILE_CODE_EMPTY;
    for (int n = 1; n <= 11; n++) begin
      if (value == (12'd1 << n)) code = CODE_W'(n);
    end
    return code;
  endfunction

endpackage

// File: rtl/board_display_encoder_if.sv
// Frame handshake from the display encoder to the VGA tile renderer.
interface board_display_encoder_if;
  import board_disp_pkg::*;

  logic                         frame_valid;
  logic                         frame_ready;
  logic [TILES*CODE_W-1:0]      tile_code;
  logic [BCD_DIGITS*4-1:0]      score_bcd;
  logic [1:0]                   status;

  modport master (
    output frame_valid, tile_code, score_bcd, status,
    input  frame_ready
  );

  modport slave (
    input  frame_valid, tile_code, score_bcd, status,
    output frame_ready
  );

endinterface

// File: rtl/board_display_encoder_bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, done pulses with the last shift.
module bin2bcd_seq
  import board_disp_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_DIGITS*4-1:0] bcd
);

  logic [SCORE_W-1:0]      bin_sr;
  logic [4:0]              cnt;
  logic [BCD_DIGITS*4-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_sr <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      bin_sr <= bin;
      bcd    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      bcd    <= {adj[BCD_DIGITS*4-2:0], bin_sr[SCORE_W-1]};
      bin_sr <= bin_sr << 1;
      cnt    <= cnt + 5'd1;
      if (cnt == 5'(SCORE_W-1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/board_display_encoder.sv
// Snapshots the game board/score on change, encodes tiles and score, and
// presents the finished frame to the renderer over a valid/ready handshake.
module board_display_encoder
  import board_disp_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [TILES*TILE_W-1:0]    matrix_in,
  input  logic [SCORE_W-1:0]         score_in,
  input  logic                       win_in,
  input  logic                       over_in,
  board_display_encoder_if.master    frame,
  output logic                       busy,
  output logic                       enc_error
);

  disp_state_t state, next_state;

  logic [TILES*TILE_W-1:0] shadow_matrix;
  logic [SCORE_W-1:0]      shadow_score;
  logic                    shadow_win;
  logic                    shadow_over;
  logic                    primed;
  logic [3:0]              idx;
  logic [TILES*CODE_W-1:0] work_code;
  logic [CODE_W-1:0]       cur_code;
  logic                    change;

  logic                    bcd_start;
  logic                    bcd_busy;
  logic                    bcd_done;
  logic [BCD_DIGITS*4-1:0] bcd_val;

  assign change = !primed ||
                  ({matrix_in, score_in, win_in, over_in} !=
                   {shadow_matrix, shadow_score, shadow_win, shadow_over});

  assign cur_code  = tile_to_code(shadow_matrix[int'(idx)*TILE_W +: TILE_W]);
  // Kick the converter on the last encode cycle so it loads as BCD is entered.
  assign bcd_start = (state == ST_ENCODE) && (idx == 4'd15);
  assign busy      = (state == ST_CAPTURE) || (state == ST_ENCODE) || (state == ST_BCD);

  bin2bcd_seq u_bin2bcd (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (bcd_start),
    .bin     (shadow_score),
    .busy    (bcd_busy),
    .done    (bcd_done),
    .bcd     (bcd_val)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (change) next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_ENCODE;
      ST_ENCODE:  if (idx == 4'd15) next_state = ST_BCD;
      ST_BCD:     if (bcd_done && !bcd_busy) next_state = ST_PRESENT;
      ST_PRESENT: if (frame.frame_ready) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state             <= ST_IDLE;
      shadow_matrix     <= '0;
      shadow_score      <= '0;
      shadow_win        <= 1'b0;
      shadow_over       <= 1'b0;
      primed            <= 1'b0;
      idx               <= '0;
      work_code         <= '0;
      enc_error         <= 1'b0;
      frame.frame_valid <= 1'b0;
      frame.tile_code   <= '0;
      frame.score_bcd   <= '0;
      frame.status      <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_CAPTURE: begin
          shadow_matrix <= matrix_in;
          shadow_score  <= score_in;
          shadow_win    <= win_in;
          shadow_over   <= over_in;
          primed        <= 1'b1;
          idx           <= '0;
        end
        ST_ENCODE: begin
          work_code[int'(idx)*CODE_W +: CODE_W] <= cur_code;
          if (cur_code == TILE_CODE_BAD) enc_error <= 1'b1;
          idx <= idx + 4'd1;
        end
        ST_BCD: begin
          // All frame outputs load together so the renderer never sees a mix.
          if (bcd_done && !bcd_busy) begin
            frame.tile_code   <= work_code;
            frame.score_bcd   <= bcd_val;
            frame.status      <= {shadow_win, shadow_over};
            frame.frame_valid <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (frame.frame_ready) frame.frame_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/board_display_encoder.md
# board_display_encoder

Downstream stage of the 2048 game core. It watches the 192-bit board snapshot, the 17-bit score and the win/over flags. On any change it captures a copy, encodes each 12-bit tile into a 4-bit exponent code, and converts the score to six BCD digits. The finished frame goes to the VGA tile renderer through a valid/ready handshake.

## Interface
- TILES, 16, number of board cells, fixed 4x4
- TILE_W, 12, bits per tile value in the input snapshot
- SCORE_W, 17, score width
- BCD_DIGITS, 6, score digits produced
- Clk  in  1  system clock; all logic on its rising edge
- Reset_n  in  1  one clock; reset is asynchronous and active-low
- matrix_in  in  192  board snapshot; tile k at bits [12k+11:12k], tile 0 top-left, row-major
- score_in  in  17  running score, binary
- win_in  in  1  game-won flag
- over_in  in  1  no-moves-left flag
- frame_ready  in  1  renderer accepts the frame this cycle
- frame_valid  out  1  frame outputs hold a complete, consistent frame
- tile_code  out  64  4 bits per tile, same ordering as matrix_in
- score_bcd  out  24  6 BCD digits, most significant digit in [23:20]
- status  out  2  {win, over} captured with the frame
- busy  out  1  a conversion is in progress
- enc_error  out  1  sticky; set when any tile held a value that is not a legal tile

## Operation
- States: IDLE, CAPTURE, ENCODE, BCD, PRESENT.
- IDLE
  - A change is detected when {matrix_in, score_in, win_in, over_in} differs from the last-captured copy, or when the primed flag is 0.
  - On a change, go to CAPTURE.
- CAPTURE
  - Register all inputs into the shadow copy.
  - Set primed to 1.
  - Set busy to 1.
  - Go to ENCODE.
- ENCODE
  - 4-bit tile index, one tile per cycle, 16 cycles.
  - Code mapping: value 0 -> 0; value 2^n for n=1..11 -> n.
  - Any other value (non-power-of-two, value 1, or above 2048) -> 4'hF, and enc_error is set.
  - Codes go into a working register, not into tile_code.
  - Go to BCD after index 15.
- BCD
  - Start the bin2bcd_seq sub-module on the shadow score.
  - Sequential double-dabble, one shift per cycle, 17 shifts.
  - Go to PRESENT when it reports done.
- PRESENT
  - On entry, tile_code, score_bcd and status load from the working registers in the same cycle.
  - frame_valid = 1 and busy = 0.
  - frame_valid and all frame outputs stay stable until frame_ready is sampled high.
  - When frame_ready is high, frame_valid drops and the FSM returns to IDLE.
- Changes on the inputs during CAPTURE..PRESENT are ignored. The shadow copy is compared again in IDLE, so the newest state is always rendered eventually. Intermediate states may be skipped.
- enc_error is cleared only by reset.
- Maximum score 131071 -> BCD 131071; no overflow is possible with 6 digits.

## Timing
- Reset values:
  - frame_valid = 0, busy = 0, enc_error = 0.
  - tile_code = 0, score_bcd = 0, status = 0.
  - primed = 0, shadow copy = 0, FSM = IDLE.
- The first conversion starts in the first cycle after reset release, even with an all-zero board.
- Latency, change visible in IDLE -> frame_valid high: 1 (IDLE) + 1 (CAPTURE) + 16 (ENCODE) + 17 (BCD) + 1 (load) = 36 cycles.
- frame_ready is ignored while frame_valid is 0.
- frame_ready held high permanently gives one frame per change, with back-to-back conversions 36 cycles apart.
- Reset asserted mid-conversion aborts it immediately. All outputs return to reset values asynchronously, and no partial frame is ever presented.
- Change and handshake in the same cycle: the frame completes handshake, the FSM enters IDLE, and the change is detected the next cycle.

## Structure
- Package board_disp_pkg holds:
  - state enum disp_state_t;
  - TILES, TILE_W, SCORE_W, BCD_DIGITS;
  - TILE_CODE_EMPTY = 0, TILE_CODE_BAD = 4'hF;
  - function tile_to_code(value) -> 4-bit code.
- One sub-module: bin2bcd_seq.
  - Ports: Clk, Reset_n, start, bin[16:0], busy, done, bcd[23:0].
  - done is a 1-cycle pulse.
  - bcd is held until the next start.
- The top holds the FSM, the shadow copy, the tile index counter and the output registers.

## Test plan
- Reset release with all-zero inputs -> frame_valid rises after 36 cycles with tile_code = 0, score_bcd = 24'h000000, status = 0.
- Board with tile0=2, tile5=64, tile15=2048, score=1234, frame_ready=1 -> tile_code[3:0]=1, [23:20]=6, [63:60]=11, score_bcd=24'h001234.
- score_in = 131071 -> score_bcd = 24'h131071; win_in=1, over_in=0 -> status = 2'b10.
- frame_ready held 0 for 50 cycles while matrix_in changes -> frame_valid and outputs constant. After frame_ready pulses, a new frame appears 36 cycles later holding the latest matrix_in.
- tile3 = 12'd3 -> tile_code[15:12] = 4'hF and enc_error = 1. enc_error stays 1 after a legal board, until Reset_n goes low.
- Reset_n low during ENCODE cycle 8 -> frame_valid = 0, busy = 0 immediately. After release, a full conversion runs with no stale codes.
